// File: rtl/pe_v2_mac_array.sv
// Vector PE: NUM_MACS unsigned MAC lanes sharing a broadcast scalar b.
// Optional output saturation is enabled by defining PE_V2_SAT_EN; the default build truncates.
module pe_v2_mac_array #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MACS   = 64,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rst_mac,
    input  logic [NUM_MACS*DATA_WIDTH-1:0] a_packed,
    input  logic [DATA_WIDTH-1:0]          b,
    input  logic [1:0]                     tsk_ctrl,
    input  logic                           mac_en,
    output logic [NUM_MACS*DATA_WIDTH-1:0] o_packed
);

    typedef enum logic [1:0] {
        OP_MAC  = 2'b00,
        OP_MUL  = 2'b01,
        OP_ADD  = 2'b10,
        OP_HOLD = 2'b11
    } op_e;

    op_e op;
    assign op = op_e'(tsk_ctrl);

    for (genvar i = 0; i < NUM_MACS; i++) begin : g_lane
        logic [DATA_WIDTH-1:0]   a_i;
        logic [2*DATA_WIDTH-1:0] prod;
        logic [ACC_WIDTH-1:0]    acc;
        logic [ACC_WIDTH-1:0]    op_next;
        logic [ACC_WIDTH-1:0]    op_start;
        logic [ACC_WIDTH-1:0]    acc_d;

        assign a_i  = a_packed[i*DATA_WIDTH +: DATA_WIDTH];
        assign prod = a_i * b;

        always_comb begin
            op_next  = acc;
            op_start = '0;
            case (op)
                OP_MAC: begin
                    op_next  = acc + ACC_WIDTH'(prod);
                    op_start = ACC_WIDTH'(prod);
                end
                OP_MUL: begin
                    op_next  = ACC_WIDTH'(prod);
                    op_start = ACC_WIDTH'(prod);
                end
                OP_ADD: begin
                    op_next  = acc + ACC_WIDTH'(a_i);
                    op_start = ACC_WIDTH'(a_i);
                end
                default: begin
                    op_next  = acc;
                    op_start = '0;
                end
            endcase
        end

        // rst_mac with mac_en loads the first term directly so no cycle is lost on restart.
        always_comb begin
            acc_d = acc;
            if (rst_mac)
                acc_d = mac_en ? op_start : '0;
            else if (mac_en)
                acc_d = op_next;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                acc <= '0;
            else
                acc <= acc_d;
        end

`ifdef PE_V2_SAT_EN
        assign o_packed[i*DATA_WIDTH +: DATA_WIDTH] =
            (|acc[ACC_WIDTH-1:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : acc[DATA_WIDTH-1:0];
`else
        assign o_packed[i*DATA_WIDTH +: DATA_WIDTH] = acc[DATA_WIDTH-1:0];
`endif
    end

endmodule

// File: tb/tb_pe_v2_mac_array.sv
// Directed self-checking bench for pe_v2_mac_array with hand-computed expectations.
module tb_pe_v2_mac_array;

    localparam int DW = 8;
    localparam int NM = 64;
    localparam int VW = NM*DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst_mac = 1'b0;
    logic [VW-1:0] a_packed = '0;
    logic [DW-1:0] b = '0;
    logic [1:0]    tsk_ctrl = 2'b00;
    logic          mac_en = 1'b0;
    logic [VW-1:0] o_packed;

    int compared = 0;
    int mismatched = 0;

    pe_v2_mac_array dut (
        .clk      (clk),
        .rst      (rst),
        .rst_mac  (rst_mac),
        .a_packed (a_packed),
        .b        (b),
        .tsk_ctrl (tsk_ctrl),
        .mac_en   (mac_en),
        .o_packed (o_packed)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_lane(input string tag, input int lane, input logic [DW-1:0] exp);
        logic [DW-1:0] obs;
        obs = o_packed[lane*DW +: DW];
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s lane%0d observed=%0d expected=%0d", tag, lane, obs, exp);
        end
    endtask

    task automatic rand_a();
        for (int i = 0; i < NM; i++) a_packed[i*DW +: DW] = DW'($urandom_range(0, 255));
    endtask

    task automatic set_a4(input int a0, input int a1, input int a2, input int a3);
        a_packed = '0;
        a_packed[0*DW +: DW] = DW'(a0);
        a_packed[1*DW +: DW] = DW'(a1);
        a_packed[2*DW +: DW] = DW'(a2);
        a_packed[3*DW +: DW] = DW'(a3);
    endtask

    initial begin
        logic [VW-1:0] exp_v;
        logic [VW-1:0] held;
        logic [DW-1:0] ovf1;
        logic [DW-1:0] ovf2;

        // Reset held low with random activity
        #2 rst = 1'b0;
        #1;
        chk_vec("reset_async", o_packed, '0);
        for (int k = 0; k < 10; k++) begin
            rand_a();
            b = DW'($urandom_range(0, 255));
            mac_en = 1'($urandom_range(0, 1));
            rst_mac = 1'($urandom_range(0, 1));
            tsk_ctrl = 2'($urandom_range(0, 3));
            cyc();
            chk_vec("reset_hold", o_packed, '0);
        end
        @(negedge clk);
        rst = 1'b1;
        mac_en = 1'b0;
        rst_mac = 1'b0;
        tsk_ctrl = 2'b00;
        cyc();
        chk_vec("reset_release", o_packed, '0);

        // 4x4 MAC
        mac_en = 1'b1;
        set_a4(1, 2, 3, 4);     b = 8'd1; cyc();
        chk_lane("mac_t1", 0, 8'd1);
        set_a4(6, 7, 8, 9);     b = 8'd2; cyc();
        set_a4(11, 12, 13, 14); b = 8'd3; cyc();
        set_a4(16, 17, 18, 19); b = 8'd4; cyc();
        exp_v = '0;
        exp_v[0*DW +: DW] = 8'd110;
        exp_v[1*DW +: DW] = 8'd120;
        exp_v[2*DW +: DW] = 8'd130;
        exp_v[3*DW +: DW] = 8'd140;
        chk_vec("mac_4x4", o_packed, exp_v);

        // Clear-and-load, lane 0
        rst_mac = 1'b1; set_a4(2, 0, 0, 0); b = 8'd1; cyc();
        exp_v = '0;
        exp_v[0*DW +: DW] = 8'd2;
        chk_vec("clr_load", o_packed, exp_v);
        rst_mac = 1'b0;
        set_a4(7, 0, 0, 0);  b = 8'd2; cyc();
        chk_lane("clr_t2", 0, 8'd16);
        set_a4(12, 0, 0, 0); b = 8'd3; cyc();
        chk_lane("clr_t3", 0, 8'd52);
        set_a4(17, 0, 0, 0); b = 8'd4; cyc();
        chk_lane("clr_t4", 0, 8'd120);
        rst_mac = 1'b1; mac_en = 1'b0; set_a4(2, 0, 0, 0); b = 8'd1; cyc();
        chk_vec("clr_only", o_packed, '0);

        // Hold: load 3,6,9,12 then freeze with changing inputs
        rst_mac = 1'b1; mac_en = 1'b1; set_a4(1, 2, 3, 4); b = 8'd3; cyc();
        held = '0;
        held[0*DW +: DW] = 8'd3;
        held[1*DW +: DW] = 8'd6;
        held[2*DW +: DW] = 8'd9;
        held[3*DW +: DW] = 8'd12;
        chk_vec("hold_load", o_packed, held);
        rst_mac = 1'b0; mac_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_a();
            b = DW'($urandom_range(1, 255));
            tsk_ctrl = 2'($urandom_range(0, 3));
            cyc();
            chk_vec("hold", o_packed, held);
        end
        rst_mac = 1'b1; tsk_ctrl = 2'b00; cyc();
        chk_vec("hold_clear", o_packed, '0);

        // Overflow: 255*255 twice -> 65025, 130050
`ifdef PE_V2_SAT_EN
        ovf1 = 8'd255;
        ovf2 = 8'd255;
`else
        ovf1 = 8'd1;
        ovf2 = 8'd2;
`endif
        rst_mac = 1'b0; mac_en = 1'b1; a_packed = '0; a_packed[0 +: DW] = 8'd255; b = 8'd255;
        cyc();
        chk_lane("ovf_1", 0, ovf1);
        cyc();
        chk_lane("ovf_2", 0, ovf2);
        chk_lane("ovf_lane1", 1, 8'd0);

        // Modes: MUL, ADD, HOLD
        tsk_ctrl = 2'b01; a_packed[0 +: DW] = 8'd3; b = 8'd5;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_lane("mode_mul", 0, 8'd15);
        end
        tsk_ctrl = 2'b10; a_packed[0 +: DW] = 8'd4; b = 8'd99;
        cyc();
        chk_lane("mode_add1", 0, 8'd19);
        cyc();
        chk_lane("mode_add2", 0, 8'd23);
        tsk_ctrl = 2'b11; a_packed[0 +: DW] = 8'd77;
        cyc();
        chk_lane("mode_hold1", 0, 8'd23);
        cyc();
        chk_lane("mode_hold2", 0, 8'd23);

        // Clear-and-load in ADD and HOLD modes
        rst_mac = 1'b1; tsk_ctrl = 2'b10; a_packed[0 +: DW] = 8'd9;
        cyc();
        chk_lane("add_load", 0, 8'd9);
        tsk_ctrl = 2'b11;
        cyc();
        chk_lane("hold_load0", 0, 8'd0);

        // Async reset mid-accumulation
        rst_mac = 1'b0; tsk_ctrl = 2'b00; a_packed[0 +: DW] = 8'd5; b = 8'd5;
        cyc();
        chk_lane("pre_areset", 0, 8'd25);
        #2 rst = 1'b0;
        #1;
        chk_vec("mid_areset", o_packed, '0);
        rst = 1'b1;
        mac_en = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
